// File: rtl/update_q_value_if.sv
// Request/memory bus between a Q-table update stage and its controller/memory.
// The master side issues requests and serves memory reads; the slave side is the update stage.
interface update_q_value_if #(
    parameter int WORD_WIDTH = 16
);
    logic                  start;
    logic [WORD_WIDTH-1:0] nbr_index;
    logic [WORD_WIDTH-1:0] nbr_mybest;
    logic [WORD_WIDTH-1:0] reward;
    logic [WORD_WIDTH-1:0] data_in;
    logic [WORD_WIDTH-1:0] address;
    logic [WORD_WIDTH-1:0] data_out;
    logic                  wr_en;
    logic                  err;
    logic                  done;

    modport master (
        output start, nbr_index, nbr_mybest, reward, data_in,
        input  address, data_out, wr_en, err, done
    );

    modport slave (
        input  start, nbr_index, nbr_mybest, reward, data_in,
        output address, data_out, wr_en, err, done
    );
endinterface

// File: rtl/update_q_value.sv
// Q-table update stage: Q_new = Q_old + (reward + nbr_mybest - Q_old) >>> ALPHA_SHIFT.
// Define QUPD_SAT_EN to clamp target and Q_new to [0, 16'hFFFE] instead of wrapping.
module update_q_value #(
    parameter int                    WORD_WIDTH   = 16,
    parameter int                    ALPHA_SHIFT  = 2,
    parameter logic [WORD_WIDTH-1:0] NBR_CNT_ADDR = 16'h068A,
    parameter logic [WORD_WIDTH-1:0] QTABLE_BASE  = 16'h01C8
) (
    input logic              clock,
    input logic              nrst,
    update_q_value_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, RD_CNT, RD_Q, CALC, WR, DONE} state_t;

    state_t state, state_next;

    logic [WORD_WIDTH-1:0] idx_q, mybest_q, reward_q, q_old;
    logic [WORD_WIDTH-1:0] idx_next, mybest_next, reward_next, q_old_next;
    logic [WORD_WIDTH-1:0] address_r, address_next, data_out_r, data_out_next;
    logic                  wr_en_r, wr_en_next, err_r, err_next, done_r, done_next;

    logic [WORD_WIDTH-1:0]        target;
    logic signed [WORD_WIDTH+1:0] delta;
    logic [WORD_WIDTH-1:0]        q_new;

`ifdef QUPD_SAT_EN
    // 16'hFFFF is reserved, so the largest legal cost is all-ones minus one
    localparam logic [WORD_WIDTH-1:0] Q_MAX = {{(WORD_WIDTH-1){1'b1}}, 1'b0};
    logic [WORD_WIDTH:0]          target_full;
    logic signed [WORD_WIDTH+2:0] q_sum;
`endif

    always_comb begin
`ifdef QUPD_SAT_EN
        target_full = {1'b0, reward_q} + {1'b0, mybest_q};
        target      = (target_full > {1'b0, Q_MAX}) ? Q_MAX : target_full[WORD_WIDTH-1:0];
`else
        target      = reward_q + mybest_q;
`endif
        delta = $signed({2'b00, target}) - $signed({2'b00, q_old});
`ifdef QUPD_SAT_EN
        q_sum = $signed({3'b000, q_old}) + (WORD_WIDTH+3)'(delta >>> ALPHA_SHIFT);
        if (q_sum < 0)
            q_new = '0;
        else if (q_sum > $signed({3'b000, Q_MAX}))
            q_new = Q_MAX;
        else
            q_new = q_sum[WORD_WIDTH-1:0];
`else
        q_new = q_old + WORD_WIDTH'(delta >>> ALPHA_SHIFT);
`endif
    end

    always_comb begin
        state_next    = state;
        idx_next      = idx_q;
        mybest_next   = mybest_q;
        reward_next   = reward_q;
        q_old_next    = q_old;
        address_next  = address_r;
        data_out_next = data_out_r;
        wr_en_next    = wr_en_r;
        err_next      = err_r;
        done_next     = done_r;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    idx_next     = bus.nbr_index;
                    mybest_next  = bus.nbr_mybest;
                    reward_next  = bus.reward;
                    address_next = NBR_CNT_ADDR;
                    err_next     = 1'b0;
                    state_next   = RD_CNT;
                end
            end
            RD_CNT: begin
                // A zero neighbour count rejects every index, including 0
                if (idx_q >= bus.data_in) begin
                    err_next   = 1'b1;
                    done_next  = 1'b1;
                    state_next = DONE;
                end else begin
                    address_next = QTABLE_BASE + {idx_q[WORD_WIDTH-2:0], 1'b0};
                    state_next   = RD_Q;
                end
            end
            RD_Q: begin
                q_old_next = bus.data_in;
                state_next = CALC;
            end
            CALC: begin
                data_out_next = q_new;
                wr_en_next    = 1'b1;
                state_next    = WR;
            end
            WR: begin
                wr_en_next = 1'b0;
                done_next  = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                if (!bus.start) begin
                    done_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            idx_q      <= '0;
            mybest_q   <= '0;
            reward_q   <= '0;
            q_old      <= '0;
            address_r  <= NBR_CNT_ADDR;
            data_out_r <= '0;
            wr_en_r    <= 1'b0;
            err_r      <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state      <= state_next;
            idx_q      <= idx_next;
            mybest_q   <= mybest_next;
            reward_q   <= reward_next;
            q_old      <= q_old_next;
            address_r  <= address_next;
            data_out_r <= data_out_next;
            wr_en_r    <= wr_en_next;
            err_r      <= err_next;
            done_r     <= done_next;
        end
    end

    assign bus.address  = address_r;
    assign bus.data_out = data_out_r;
    assign bus.wr_en    = wr_en_r;
    assign bus.err      = err_r;
    assign bus.done     = done_r;
endmodule

// File: tb/tb_update_q_value.sv
// Bench for update_q_value: a default-alpha DUT and an ALPHA_SHIFT=0 DUT share one request stream,
// each with its own memory, and results are compared against an arithmetic model of the update rule.
module tb_update_q_value;
    logic        clock = 1'b0;
    logic        nrst;
    logic        start;
    logic [15:0] nbr_index, nbr_mybest, reward;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clock = ~clock;

    update_q_value_if bus2();
    update_q_value_if bus0();

    logic [15:0] mem2 [65536];
    logic [15:0] mem0 [65536];

    assign bus2.start      = start;
    assign bus2.nbr_index  = nbr_index;
    assign bus2.nbr_mybest = nbr_mybest;
    assign bus2.reward     = reward;
    assign bus2.data_in    = mem2[bus2.address];
    assign bus0.start      = start;
    assign bus0.nbr_index  = nbr_index;
    assign bus0.nbr_mybest = nbr_mybest;
    assign bus0.reward     = reward;
    assign bus0.data_in    = mem0[bus0.address];

    always @(posedge clock) begin
        if (nrst && bus2.wr_en) mem2[bus2.address] <= bus2.data_out;
        if (nrst && bus0.wr_en) mem0[bus0.address] <= bus0.data_out;
    end

    update_q_value u_dut (.clock(clock), .nrst(nrst), .bus(bus2));
    update_q_value #(.ALPHA_SHIFT(0)) u_dut_a0 (.clock(clock), .nrst(nrst), .bus(bus0));

    // Update rule in plain integer arithmetic: floor division by 2^shift, then wrap or clamp
    function automatic logic [15:0] model_q(input int q_old, input int rwd, input int mb, input int shift);
        int target, delta, d, step, qn;
        target = rwd + mb;
`ifdef QUPD_SAT_EN
        if (target > 65534) target = 65534;
`else
        target = target % 65536;
`endif
        delta = target - q_old;
        d = 1 << shift;
        if (delta >= 0) step = delta / d;
        else            step = -((-delta + d - 1) / d);
        qn = q_old + step;
`ifdef QUPD_SAT_EN
        if (qn < 0)     qn = 0;
        if (qn > 65534) qn = 65534;
`else
        qn = ((qn % 65536) + 65536) % 65536;
`endif
        return 16'(qn);
    endfunction

    function automatic logic [15:0] entry_addr(input logic [15:0] idx);
        return 16'((32'h01C8 + 2 * int'(idx)) % 65536);
    endfunction

    task automatic mem_set(input logic [15:0] addr, input logic [15:0] val);
        mem2[addr] = val;
        mem0[addr] = val;
    endtask

    // Issues one request, scrambles the inputs after they were sampled, and watches hold extra edges after done
    task automatic do_request(input logic [15:0] idx, input logic [15:0] mb, input logic [15:0] rw, input int hold,
                              output int wr2_cnt, output logic [15:0] wr2_addr, output logic [15:0] wr2_data,
                              output int wr0_cnt, output logic [15:0] wr0_data,
                              output int wr_cycle, output int done_cycle, output bit done_dropped);
        wr2_cnt = 0; wr0_cnt = 0; wr2_addr = 'x; wr2_data = 'x; wr0_data = 'x;
        wr_cycle = -1; done_cycle = -1; done_dropped = 0;
        @(negedge clock);
        nbr_index = idx; nbr_mybest = mb; reward = rw; start = 1'b1;
        for (int e = 0; e < 24; e++) begin
            @(posedge clock); #1;
            if (e == 0) begin
                nbr_index = 16'($urandom); nbr_mybest = 16'($urandom); reward = 16'($urandom);
            end
            if (bus2.wr_en) begin wr2_cnt++; wr2_addr = bus2.address; wr2_data = bus2.data_out; wr_cycle = e; end
            if (bus0.wr_en) begin wr0_cnt++; wr0_data = bus0.data_out; end
            if (done_cycle >= 0 && !bus2.done) done_dropped = 1;
            if (done_cycle < 0 && bus2.done) done_cycle = e;
            if (done_cycle >= 0 && e >= done_cycle + hold) break;
        end
    endtask

    task automatic release_start(output logic done_after);
        @(negedge clock);
        start = 1'b0;
        @(posedge clock); #1;
        done_after = bus2.done;
    endtask

    task automatic test_reset;
        nrst = 1'b0; start = 1'b0; nbr_index = '0; nbr_mybest = '0; reward = '0;
        #12;
        checks++; if (bus2.address !== 16'h068A) begin fails++; $display("[TB] FAIL reset_address: got %h expected 068a", bus2.address); end else passes++;
        checks++; if (bus2.data_out !== 16'h0000) begin fails++; $display("[TB] FAIL reset_data_out: got %h expected 0000", bus2.data_out); end else passes++;
        checks++; if (bus2.wr_en !== 1'b0 || bus0.wr_en !== 1'b0) begin fails++; $display("[TB] FAIL reset_wr_en: got %b/%b expected 0/0", bus2.wr_en, bus0.wr_en); end else passes++;
        checks++; if (bus2.err !== 1'b0) begin fails++; $display("[TB] FAIL reset_err: got %b expected 0", bus2.err); end else passes++;
        checks++; if (bus2.done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b expected 0", bus2.done); end else passes++;
        @(negedge clock);
        nrst = 1'b1;
    endtask

    task automatic test_nominal;
        int w2, w0, wc, dc; logic [15:0] a2, d2, d0; bit dd; logic da;
        mem_set(16'h068A, 16'd3);
        mem_set(16'h01CA, 16'h0200);
        do_request(16'd1, 16'h0100, 16'h0020, 0, w2, a2, d2, w0, d0, wc, dc, dd);
        checks++; if (w2 !== 1) begin fails++; $display("[TB] FAIL nominal_wr_count: got %0d expected 1", w2); end else passes++;
        checks++; if (a2 !== 16'h01CA) begin fails++; $display("[TB] FAIL nominal_address: got %h expected 01ca", a2); end else passes++;
        checks++; if (d2 !== 16'h01C8) begin fails++; $display("[TB] FAIL nominal_data: got %h expected 01c8", d2); end else passes++;
        checks++; if (wc !== 3) begin fails++; $display("[TB] FAIL nominal_wr_latency: got %0d expected 3", wc); end else passes++;
        checks++; if (dc !== 4) begin fails++; $display("[TB] FAIL nominal_done_latency: got %0d expected 4", dc); end else passes++;
        checks++; if (bus2.err !== 1'b0) begin fails++; $display("[TB] FAIL nominal_err: got %b expected 0", bus2.err); end else passes++;
        checks++; if (mem2[16'h01CA] !== 16'h01C8) begin fails++; $display("[TB] FAIL nominal_table: got %h expected 01c8", mem2[16'h01CA]); end else passes++;
        checks++; if (d0 !== 16'h0120) begin fails++; $display("[TB] FAIL alpha0_data: got %h expected 0120", d0); end else passes++;
        release_start(da);
        checks++; if (da !== 1'b0) begin fails++; $display("[TB] FAIL nominal_done_clear: got %b expected 0", da); end else passes++;
    endtask

    task automatic test_range_err;
        int w2, w0, wc, dc; logic [15:0] a2, d2, d0; bit dd; logic da;
        mem_set(16'h068A, 16'd3);
        mem_set(16'h01CE, 16'h1234);
        do_request(16'd3, 16'h0100, 16'h0020, 0, w2, a2, d2, w0, d0, wc, dc, dd);
        checks++; if (bus2.err !== 1'b1) begin fails++; $display("[TB] FAIL range_err_flag: got %b expected 1", bus2.err); end else passes++;
        checks++; if (w2 !== 0 || w0 !== 0) begin fails++; $display("[TB] FAIL range_err_writes: got %0d/%0d expected 0/0", w2, w0); end else passes++;
        checks++; if (dc !== 1) begin fails++; $display("[TB] FAIL range_err_done_latency: got %0d expected 1", dc); end else passes++;
        checks++; if (mem2[16'h01CE] !== 16'h1234) begin fails++; $display("[TB] FAIL range_err_table: got %h expected 1234", mem2[16'h01CE]); end else passes++;
        release_start(da);
        mem_set(16'h068A, 16'd0);
        do_request(16'd0, 16'h0100, 16'h0020, 0, w2, a2, d2, w0, d0, wc, dc, dd);
        checks++; if (bus2.err !== 1'b1 || w2 !== 0) begin fails++; $display("[TB] FAIL zero_count_err: got err=%b writes=%0d expected err=1 writes=0", bus2.err, w2); end else passes++;
        release_start(da);
    endtask

    task automatic test_overflow;
        int w2, w0, wc, dc; logic [15:0] a2, d2, d0, exp_d; bit dd; logic da;
`ifdef QUPD_SAT_EN
        exp_d = 16'hFFFE;
`else
        exp_d = 16'hC03E;
`endif
        mem_set(16'h068A, 16'd5);
        mem_set(16'h01CC, 16'hFFFE);
        do_request(16'd2, 16'h0200, 16'hFF00, 0, w2, a2, d2, w0, d0, wc, dc, dd);
        checks++; if (d2 !== exp_d) begin fails++; $display("[TB] FAIL overflow_data: got %h expected %h", d2, exp_d); end else passes++;
        checks++; if (d0 !== model_q(16'hFFFE, 16'hFF00, 16'h0200, 0)) begin fails++; $display("[TB] FAIL overflow_alpha0: got %h expected %h", d0, model_q(16'hFFFE, 16'hFF00, 16'h0200, 0)); end else passes++;
        release_start(da);
    endtask

    task automatic test_boundaries;
        int w2, w0, wc, dc; logic [15:0] a2, d2, d0; bit dd; logic da;
        mem_set(16'h068A, 16'd4);
        mem_set(16'h01C8, 16'h0500);
        do_request(16'd0, 16'h0333, 16'h0044, 0, w2, a2, d2, w0, d0, wc, dc, dd);
        checks++; if (a2 !== 16'h01C8) begin fails++; $display("[TB] FAIL idx0_address: got %h expected 01c8", a2); end else passes++;
        checks++; if (d0 !== 16'h0377) begin fails++; $display("[TB] FAIL alpha0_sum: got %h expected 0377", d0); end else passes++;
        checks++; if (d2 !== model_q(16'h0500, 16'h0044, 16'h0333, 2)) begin fails++; $display("[TB] FAIL idx0_data: got %h expected %h", d2, model_q(16'h0500, 16'h0044, 16'h0333, 2)); end else passes++;
        release_start(da);
        mem_set(16'h068A, 16'hFFFF);
        mem_set(16'h01C8, 16'h0040);
        do_request(16'h8000, 16'h0010, 16'h0010, 0, w2, a2, d2, w0, d0, wc, dc, dd);
        checks++; if (a2 !== entry_addr(16'h8000) || w2 !== 1) begin fails++; $display("[TB] FAIL wrap_address: got %h writes=%0d expected %h writes=1", a2, w2, entry_addr(16'h8000)); end else passes++;
        release_start(da);
    endtask

    task automatic test_back_to_back;
        int w2, w0, wc, dc; logic [15:0] a2, d2, d0; bit dd; logic da;
        mem_set(16'h068A, 16'd8);
        mem_set(16'h01D2, 16'h0100);
        do_request(16'd5, 16'h0080, 16'h0040, 10, w2, a2, d2, w0, d0, wc, dc, dd);
        checks++; if (w2 !== 1) begin fails++; $display("[TB] FAIL held_start_writes: got %0d expected 1", w2); end else passes++;
        checks++; if (dd !== 1'b0 || bus2.done !== 1'b1) begin fails++; $display("[TB] FAIL held_start_done: got dropped=%b done=%b expected dropped=0 done=1", dd, bus2.done); end else passes++;
        release_start(da);
        checks++; if (da !== 1'b0) begin fails++; $display("[TB] FAIL held_start_release: got %b expected 0", da); end else passes++;
        mem_set(16'h01D2, 16'h7000);
        do_request(16'd5, 16'h1000, 16'h0200, 0, w2, a2, d2, w0, d0, wc, dc, dd);
        checks++; if (d2 !== model_q(16'h7000, 16'h0200, 16'h1000, 2) || w2 !== 1) begin fails++; $display("[TB] FAIL back_to_back_data: got %h writes=%0d expected %h writes=1", d2, w2, model_q(16'h7000, 16'h0200, 16'h1000, 2)); end else passes++;
        release_start(da);
    endtask

    task automatic test_reset_midop;
        bit seen = 0;
        mem_set(16'h068A, 16'd6);
        mem_set(16'h01D0, 16'h4321);
        @(negedge clock);
        nbr_index = 16'd4; nbr_mybest = 16'h0800; reward = 16'h0100; start = 1'b1;
        for (int e = 0; e < 12 && !seen; e++) begin
            @(posedge clock); #1;
            if (bus2.wr_en) seen = 1;
        end
        checks++; if (!seen) begin fails++; $display("[TB] FAIL midop_reach_wr: got no write strobe expected one within 12 edges"); end else passes++;
        nrst = 1'b0;
        #1;
        checks++; if (bus2.wr_en !== 1'b0 || bus0.wr_en !== 1'b0) begin fails++; $display("[TB] FAIL midop_wr_en: got %b/%b expected 0/0", bus2.wr_en, bus0.wr_en); end else passes++;
        checks++; if (bus2.address !== 16'h068A || bus2.data_out !== 16'h0000 || bus2.done !== 1'b0 || bus2.err !== 1'b0) begin
            fails++; $display("[TB] FAIL midop_outputs: got addr=%h data=%h done=%b err=%b expected 068a/0000/0/0", bus2.address, bus2.data_out, bus2.done, bus2.err);
        end else passes++;
        @(posedge clock); #1;
        checks++; if (mem2[16'h01D0] !== 16'h4321 || mem0[16'h01D0] !== 16'h4321) begin fails++; $display("[TB] FAIL midop_table: got %h/%h expected 4321", mem2[16'h01D0], mem0[16'h01D0]); end else passes++;
        start = 1'b0;
        @(negedge clock);
        nrst = 1'b1;
    endtask

    task automatic test_random;
        int w2, w0, wc, dc; logic [15:0] a2, d2, d0, cnt, idx, q, mb, rw; bit dd; logic da;
        for (int i = 0; i < 24; i++) begin
            cnt = 16'($urandom_range(1, 12));
            idx = 16'($urandom_range(0, 15));
            q = 16'($urandom); mb = 16'($urandom); rw = 16'($urandom);
            mem_set(16'h068A, cnt);
            mem_set(entry_addr(idx), q);
            do_request(idx, mb, rw, 0, w2, a2, d2, w0, d0, wc, dc, dd);
            if (idx >= cnt) begin
                checks++; if (bus2.err !== 1'b1 || w2 !== 0 || w0 !== 0) begin fails++; $display("[TB] FAIL random_err[%0d]: got err=%b writes=%0d/%0d expected err=1 writes=0", i, bus2.err, w2, w0); end else passes++;
            end else begin
                checks++; if (bus2.err !== 1'b0 || w2 !== 1 || a2 !== entry_addr(idx)) begin fails++; $display("[TB] FAIL random_write[%0d]: got err=%b writes=%0d addr=%h expected err=0 writes=1 addr=%h", i, bus2.err, w2, a2, entry_addr(idx)); end else passes++;
                checks++; if (d2 !== model_q(q, rw, mb, 2)) begin fails++; $display("[TB] FAIL random_data[%0d]: got %h expected %h", i, d2, model_q(q, rw, mb, 2)); end else passes++;
                checks++; if (d0 !== model_q(q, rw, mb, 0)) begin fails++; $display("[TB] FAIL random_alpha0[%0d]: got %h expected %h", i, d0, model_q(q, rw, mb, 0)); end else passes++;
            end
            release_start(da);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_range_err();
        test_overflow();
        test_boundaries();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
